fallthrough_small_fifo: RTL and testbench

//  Small synchronous first-word-fall-through FIFO used as the input buffer of

---
 rtl/fallthrough_small_fifo_pkg.sv | 27 ++
 rtl/fallthrough_small_fifo.sv | 83 ++++++++
 tb/tb_fallthrough_small_fifo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fallthrough_small_fifo_pkg.sv
// fallthrough_small_fifo_pkg: shared flag struct and occupancy decode for the fall-through FIFO
//   fifo_flags_t  : {full, nearly_full, prog_full, empty}
//   decode_flags  : derives all status flags from the current occupancy
package fallthrough_small_fifo_pkg;

    typedef struct packed {
        logic full;
        logic nearly_full;
        logic prog_full;
        logic empty;
    } fifo_flags_t;

    // Pure combinational decode of occupancy; flags carry no register stage.
    function automatic fifo_flags_t decode_flags(
        input logic [31:0] cnt,
        input logic [31:0] depth,
        input logic [31:0] thr
    );
        fifo_flags_t f;
        f.full        = (cnt == depth);
        f.nearly_full = (cnt >= depth - 32'd1);
        f.prog_full   = (cnt >= thr);
        f.empty       = (cnt == 32'd0);
        return f;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: small first-word-fall-through FIFO for packed {ctrl,data} words
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous active-low reset
//   din          in   WIDTH  write data
//   wr_en        in   1      push din
//   rd_en        in   1      pop current head word
//   dout         out  WIDTH  head word while non-empty, zero when empty
//   full         out  1      occupancy == DEPTH
//   nearly_full  out  1      occupancy >= DEPTH-1
//   prog_full    out  1      occupancy >= PROG_FULL_THRESHOLD
//   empty        out  1      occupancy == 0
// Optional macro FALLTHROUGH_FIFO_ERR_CHECK_EN adds simulation-only overflow/underflow messages.
module fallthrough_small_fifo
    import fallthrough_small_fifo_pkg::*;
#(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);

    localparam int DEPTH = 2**MAX_DEPTH_BITS;
    localparam int CNT_W = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]          count;
    logic                      do_wr;
    logic                      do_rd;
    fifo_flags_t               flags;

    // A full FIFO still accepts a write when the head is popped on the same edge.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    assign flags = decode_flags(32'(count), 32'(DEPTH), 32'(PROG_FULL_THRESHOLD));
    assign full        = flags.full;
    assign nearly_full = flags.nearly_full;
    assign prog_full   = flags.prog_full;
    assign empty       = flags.empty;

    assign dout = empty ? '0 : mem[rd_ptr];

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at DEPTH, so no explicit wrap logic is needed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd) count <= count + 1'b1;
            else if (do_rd && !do_wr) count <= count - 1'b1;
        end
    end

`ifdef FALLTHROUGH_FIFO_ERR_CHECK_EN
    always @(posedge clk) begin
        if (reset) begin
            if (wr_en && full && !rd_en) $display("%m: write to full fifo");
            if (rd_en && empty) $display("%m: read from empty fifo");
        end
    end
`endif

endmodule

// File: tb/tb_fallthrough_small_fifo.sv
// tb_fallthrough_small_fifo: directed self-checking bench for fallthrough_small_fifo (WIDTH=72, depth 8)
module tb_fallthrough_small_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [71:0] din = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [71:0] dout;
    logic        full;
    logic        nearly_full;
    logic        prog_full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    fallthrough_small_fifo #(.WIDTH(72), .MAX_DEPTH_BITS(3)) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .dout(dout),
        .full(full),
        .nearly_full(nearly_full),
        .prog_full(prog_full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic w, input logic r, input logic [71:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [71:0] pat;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 72'(empty), 72'd1);
        check("rst_full", 72'(full), 72'd0);
        check("rst_nfull", 72'(nearly_full), 72'd0);
        check("rst_pfull", 72'(prog_full), 72'd0);
        check("rst_dout", dout, 72'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        cycle(1, 0, 72'h11);
        check("ft_empty", 72'(empty), 72'd0);
        check("ft_dout1", dout, 72'h11);
        cycle(1, 0, 72'h22);
        cycle(1, 0, 72'h33);
        check("ft_dout3", dout, 72'h11);
        cycle(0, 1, '0);
        check("pop1", dout, 72'h22);
        cycle(0, 1, '0);
        check("pop2", dout, 72'h33);
        cycle(0, 1, '0);
        check("pop3_empty", 72'(empty), 72'd1);
        check("pop3_dout", dout, 72'd0);

        for (int i = 0; i < 7; i++) cycle(1, 0, 72'h100 + 72'(i));
        check("w7_nfull", 72'(nearly_full), 72'd1);
        check("w7_pfull", 72'(prog_full), 72'd1);
        check("w7_full", 72'(full), 72'd0);
        cycle(1, 0, 72'h107);
        check("w8_full", 72'(full), 72'd1);
        cycle(1, 0, 72'hDEAD);
        check("w9_full", 72'(full), 72'd1);
        check("w9_count", 72'(dut.count), 72'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), dout, 72'h100 + 72'(i));
            cycle(0, 1, '0);
        end
        check("drain_empty", 72'(empty), 72'd1);

        for (int i = 0; i < 8; i++) cycle(1, 0, 72'h200 + 72'(i));
        cycle(1, 1, 72'h2FF);
        check("rw_full", 72'(full), 72'd1);
        check("rw_head", dout, 72'h201);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("rw_pop%0d", i), dout, 72'h200 + 72'(i));
            cycle(0, 1, '0);
        end
        check("rw_last", dout, 72'h2FF);
        cycle(0, 1, '0);
        check("rw_empty", 72'(empty), 72'd1);

        cycle(1, 1, 72'hAB);
        check("er_empty", 72'(empty), 72'd0);
        check("er_dout", dout, 72'hAB);
        check("er_count", 72'(dut.count), 72'd1);
        cycle(0, 1, '0);
        check("er_pop", 72'(empty), 72'd1);

        for (int i = 0; i < 20; i++) begin
            pat = (i % 2 == 0) ? 72'h55_5555_5555_5555_5555 : 72'hAA_AAAA_AAAA_AAAA_AAAA;
            pat = pat ^ 72'(i);
            cycle(1, 0, pat);
            check($sformatf("wrap_d%0d", i), dout, pat);
            cycle(0, 1, '0);
            check($sformatf("wrap_e%0d", i), 72'(empty), 72'd1);
        end

        for (int i = 0; i < 4; i++) cycle(1, 0, 72'h300 + 72'(i));
        check("mid_count", 72'(dut.count), 72'd4);
        check("mid_head", dout, 72'h300);
        #2 reset = 1'b0;
        #1;
        check("arst_empty", 72'(empty), 72'd1);
        check("arst_dout", dout, 72'd0);
        check("arst_count", 72'(dut.count), 72'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_empty", 72'(empty), 72'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
